// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the memory stage: opcodes, funct3 codes, FSM states.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // True when funct3 names a supported access width for a load or a store.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store replication/byte enables and load extraction/extension.
module mem_lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] store_wdata,
    output logic [3:0]  store_be,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicate store data across lanes and enable only the addressed bytes.
    always_comb begin
        store_wdata = '0;
        store_be    = '0;
        case (funct3)
            F3_SB: begin
                store_wdata = {4{store_data[7:0]}};
                store_be    = 4'b0001 << offset;
            end
            F3_SH: begin
                store_wdata = {2{store_data[15:0]}};
                store_be    = offset[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW: begin
                store_wdata = store_data;
                store_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        ld_half = offset[1] ? load_word[31:16] : load_word[15:0];
        ld_byte = offset[0] ? ld_half[15:8] : ld_half[7:0];
    end

    // Sign- or zero-extend to XLEN according to the load width.
    always_comb begin
        load_data = load_word;
        case (funct3)
            F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  load_data = {24'h0, ld_byte};
            F3_LHU:  load_data = {16'h0, ld_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory handshake FSM, load alignment and write-back select.
module mem_stage
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  wbaddr_i,
    input  logic [31:0] instr_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        wb_en_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wbaddr_o,
    output logic        exc_o
);

    mem_state_e  state_q;
    mem_state_e  state_d;
    logic [31:0] ld_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        bubble;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        misaligned;
    logic        exc;
    logic        mem_op;
    logic        req;
    logic        capture;
    logic        writes_rd;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;
    logic        unused_bits;

    assign opcode      = instr_i[6:0];
    assign funct3      = instr_i[14:12];
    assign unused_bits = ^{instr_i[31:15], instr_i[11:7]};
    assign bubble      = (instr_i == '0);
    assign is_load     = (opcode == OPC_LOAD);
    assign is_store    = (opcode == OPC_STORE);
    assign is_mem      = is_load | is_store;

    // Address must be a multiple of the access size.
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = alu_i[0];
            2'b10:   misaligned = |alu_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign exc    = is_mem & (~f3_legal(is_store, funct3) | misaligned);
    assign mem_op = is_mem & ~exc;

    // State register and load-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                ld_q <= dmem_rdata_i;
            end
        end
    end

    // Handshake sequencing; stall depends only on state and the decoded instruction.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall_o = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    req     = 1'b1;
                    stall_o = 1'b1;
                    if (dmem_gnt_i) begin
                        state_d = is_store ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    mem_lsu_align u_align (
        .funct3      (funct3),
        .offset      (alu_i[1:0]),
        .store_data  (data_i),
        .load_word   (ld_q),
        .store_wdata (st_wdata),
        .store_be    (st_be),
        .load_data   (ld_data)
    );

    assign dmem_req_o   = req;
    assign dmem_we_o    = req & is_store;
    assign dmem_addr_o  = mem_op ? {alu_i[31:2], 2'b00} : '0;
    assign dmem_wdata_o = dmem_we_o ? st_wdata : '0;
    assign dmem_be_o    = dmem_we_o ? st_be : '0;

    // Which opcodes produce a register result; loads only once their data is in.
    always_comb begin
        writes_rd = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM: writes_rd = 1'b1;
            OPC_LOAD: writes_rd = (state_q == DONE);
            default:  writes_rd = 1'b0;
        endcase
    end

    // Write-back value select: link address, aligned load, or ALU result.
    always_comb begin
        wb_data_o = alu_i;
        if (bubble) begin
            wb_data_o = '0;
        end else if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
            wb_data_o = pc_next_i;
        end else if (is_load) begin
            wb_data_o = ld_data;
        end
    end

    assign wb_en_o  = writes_rd & (wbaddr_i != 5'd0) & ~exc;
    assign wbaddr_o = wbaddr_i;
    assign exc_o    = exc;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, reset corner cases, random ops vs. model.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_next_i;
    logic [31:0] alu_i;
    logic [31:0] data_i;
    logic [4:0]  wbaddr_i;
    logic [31:0] instr_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic        wb_en_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wbaddr_o;
    logic        exc_o;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .pc_next_i     (pc_next_i),
        .alu_i         (alu_i),
        .data_i        (data_i),
        .wbaddr_i      (wbaddr_i),
        .instr_i       (instr_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_o       (stall_o),
        .wb_en_o       (wb_en_o),
        .wb_data_o     (wb_data_o),
        .wbaddr_o      (wbaddr_o),
        .exc_o         (exc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        int          gnt_dly;
        int          rv_dly;
        logic        exp_wb_en;
        logic        exp_exc;
        logic        exp_we;
        logic        chk_wb;
        logic [31:0] exp_wb;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        int          exp_stalls;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {17'h0, f3, rd, opc};
    endfunction

    function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] alu,
                                 input logic [31:0] data, input logic [31:0] rdata,
                                 input logic [4:0] rd, input int g, input int r,
                                 input logic en, input logic [31:0] wb, input logic exc,
                                 input logic chkwb, input int st, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata, input logic we);
        vec_t v;
        v.instr = instr; v.alu = alu; v.data = data; v.rdata = rdata; v.pc = 32'h0000_1004;
        v.rd = rd; v.gnt_dly = g; v.rv_dly = r;
        v.exp_wb_en = en; v.exp_wb = wb; v.exp_exc = exc; v.chk_wb = chkwb;
        v.exp_stalls = st; v.exp_addr = addr; v.exp_be = be; v.exp_wdata = wdata; v.exp_we = we;
        return v;
    endfunction

    // Reference model: expected results from the ISA rules, using plain arithmetic.
    function automatic vec_t fill_expect(input vec_t v);
        vec_t        e;
        logic [6:0]  opc;
        int          f3;
        int          off;
        int          size;
        bit          is_ld;
        bit          is_st;
        bit          legal;
        bit          mem;
        bit          wr;
        logic [31:0] mask;
        logic [31:0] raw;
        e     = v;
        opc   = v.instr[6:0];
        f3    = int'(v.instr[14:12]);
        off   = int'(v.alu[1:0]);
        is_ld = (opc == 7'h03);
        is_st = (opc == 7'h23);
        size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : (f3 % 4 == 2) ? 4 : 0;
        legal = is_ld ? (f3 inside {0, 1, 2, 4, 5}) : (f3 inside {0, 1, 2});
        e.exp_exc = (is_ld || is_st) && (!legal ? 1'b1 : ((off % size) != 0));
        mem = (is_ld || is_st) && !e.exp_exc;
        e.exp_stalls = !mem ? 0 : is_st ? v.gnt_dly + 1 : v.gnt_dly + v.rv_dly + 2;
        e.exp_addr   = mem ? (v.alu & 32'hFFFF_FFFC) : 32'h0;
        e.exp_we     = mem && is_st;
        e.exp_be     = 4'h0;
        e.exp_wdata  = 32'h0;
        if (e.exp_we) begin
            e.exp_be    = 4'(((1 << size) - 1) << off);
            e.exp_wdata = (size == 1) ? (v.data & 32'hFF) * 32'h0101_0101 :
                          (size == 2) ? (v.data & 32'hFFFF) * 32'h0001_0001 : v.data;
        end
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
        raw  = (v.rdata >> (8 * off)) & mask;
        if (f3 < 4 && size > 0 && size < 4 && ((raw >> (8 * size - 1)) & 32'h1) != 0)
            raw = raw | ~mask;
        wr = (opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h33, 7'h13}) || (is_ld && mem);
        e.exp_wb_en = wr && (v.rd != 5'd0) && !e.exp_exc;
        e.exp_wb = (v.instr == 32'h0) ? 32'h0 :
                   (opc == 7'h6F || opc == 7'h67) ? v.pc :
                   is_ld ? raw : v.alu;
        e.chk_wb = !(is_ld && e.exp_exc);
        return e;
    endfunction

    // Present one instruction, play the memory side, and check the whole transaction.
    task automatic run_op(input vec_t v);
        int          cyc;
        int          stalls;
        int          reqs;
        int          wait_cnt;
        int          exp_reqs;
        bit          granted;
        bit          got;
        bit          done;
        bit          lanes_ok;
        logic        f_wb_en;
        logic        f_exc;
        logic        f_req;
        logic [31:0] f_wb;
        logic [4:0]  f_wbaddr;
        cyc = 0; stalls = 0; reqs = 0; wait_cnt = 0;
        granted = 0; got = 0; done = 0; lanes_ok = 1;
        f_wb_en = 0; f_exc = 0; f_req = 0; f_wb = '0; f_wbaddr = '0;
        exp_reqs = (v.exp_stalls > 0) ? v.gnt_dly + 1 : 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (cyc == 0) begin
                instr_i = v.instr; alu_i = v.alu; data_i = v.data;
                wbaddr_i = v.rd; pc_next_i = v.pc;
            end
            if (granted && !got) begin
                dmem_rvalid_i = (wait_cnt == v.rv_dly);
                dmem_rdata_i  = dmem_rvalid_i ? v.rdata : $urandom;
                wait_cnt++;
                if (dmem_rvalid_i) got = 1;
            end else begin
                dmem_rvalid_i = 1'($urandom_range(0, 1));
                dmem_rdata_i  = $urandom;
            end
            dmem_gnt_i = 1'b0;
            #1;
            if (dmem_req_o) begin
                if (dmem_addr_o !== v.exp_addr || dmem_be_o !== v.exp_be ||
                    dmem_wdata_o !== v.exp_wdata || dmem_we_o !== v.exp_we)
                    lanes_ok = 0;
                dmem_gnt_i = (reqs == v.gnt_dly);
                reqs++;
                if (dmem_gnt_i && !v.exp_we) granted = 1;
            end else begin
                dmem_gnt_i = 1'($urandom_range(0, 1));
            end
            if (stall_o) begin
                stalls++;
            end else begin
                done = 1;
                f_wb_en = wb_en_o; f_exc = exc_o; f_req = dmem_req_o;
                f_wb = wb_data_o; f_wbaddr = wbaddr_o;
            end
            cyc++;
        end
        chk("completed", 32'(done), 32'h1);
        chk("stall_cycles", 32'(stalls), 32'(v.exp_stalls));
        chk("req_cycles", 32'(reqs), 32'(exp_reqs));
        if (exp_reqs > 0) chk("req_fields", 32'(lanes_ok), 32'h1);
        chk("final_req", 32'(f_req), 32'h0);
        chk("exc", 32'(f_exc), 32'(v.exp_exc));
        chk("wb_en", 32'(f_wb_en), 32'(v.exp_wb_en));
        chk("wbaddr", 32'(f_wbaddr), 32'(v.rd));
        if (v.chk_wb) chk("wb_data", f_wb, v.exp_wb);
    endtask

    task automatic idle_inputs();
        instr_i = '0; alu_i = '0; data_i = '0; wbaddr_i = '0; pc_next_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    endtask

    vec_t tbl[16];
    vec_t rv;

    initial begin
        tbl[0]  = mkv(enc(7'h33, 3'd0, 5'd5), 32'h1234, 0, 0, 5'd5, 0, 0,
                      1, 32'h1234, 0, 1, 0, 0, 4'h0, 0, 0);
        tbl[1]  = mkv(enc(7'h23, 3'd0, 5'd3), 32'h103, 32'hAB, 0, 5'd3, 0, 0,
                      0, 32'h103, 0, 1, 1, 32'h100, 4'h8, 32'hABAB_ABAB, 1);
        tbl[2]  = mkv(enc(7'h03, 3'd0, 5'd7), 32'h202, 0, 32'h0080_0000, 5'd7, 0, 1,
                      1, 32'hFFFF_FF80, 0, 1, 3, 32'h200, 4'h0, 0, 0);
        tbl[3]  = mkv(enc(7'h03, 3'd4, 5'd7), 32'h202, 0, 32'h0080_0000, 5'd7, 0, 1,
                      1, 32'h0000_0080, 0, 1, 3, 32'h200, 4'h0, 0, 0);
        tbl[4]  = mkv(enc(7'h03, 3'd2, 5'd4), 32'h302, 0, 0, 5'd4, 0, 0,
                      0, 0, 1, 0, 0, 0, 4'h0, 0, 0);
        tbl[5]  = mkv(enc(7'h03, 3'd2, 5'd8), 32'h400, 0, 32'h1234_5678, 5'd8, 3, 0,
                      1, 32'h1234_5678, 0, 1, 5, 32'h400, 4'h0, 0, 0);
        tbl[6]  = mkv(enc(7'h6F, 3'd0, 5'd1), 32'h55, 0, 0, 5'd1, 0, 0,
                      1, 32'h1004, 0, 1, 0, 0, 4'h0, 0, 0);
        tbl[7]  = mkv(enc(7'h63, 3'd0, 5'd0), 32'h1, 0, 0, 5'd0, 0, 0,
                      0, 32'h1, 0, 1, 0, 0, 4'h0, 0, 0);
        tbl[8]  = mkv(enc(7'h33, 3'd0, 5'd0), 32'h77, 0, 0, 5'd0, 0, 0,
                      0, 32'h77, 0, 1, 0, 0, 4'h0, 0, 0);
        tbl[9]  = mkv(enc(7'h23, 3'd1, 5'd0), 32'h106, 32'h1234_CDEF, 0, 5'd0, 1, 0,
                      0, 32'h106, 0, 1, 2, 32'h104, 4'hC, 32'hCDEF_CDEF, 1);
        tbl[10] = mkv(enc(7'h03, 3'd1, 5'd10), 32'h502, 0, 32'h8001_0000, 5'd10, 0, 2,
                      1, 32'hFFFF_8001, 0, 1, 4, 32'h500, 4'h0, 0, 0);
        tbl[11] = mkv(enc(7'h23, 3'd3, 5'd0), 32'h700, 32'h5, 0, 5'd0, 0, 0,
                      0, 32'h700, 1, 1, 0, 0, 4'h0, 0, 0);
        tbl[12] = mkv(enc(7'h03, 3'd5, 5'd11), 32'h501, 0, 0, 5'd11, 0, 0,
                      0, 0, 1, 0, 0, 0, 4'h0, 0, 0);
        tbl[13] = mkv(enc(7'h37, 3'd0, 5'd2), 32'hABCD_E000, 0, 0, 5'd2, 0, 0,
                      1, 32'hABCD_E000, 0, 1, 0, 0, 4'h0, 0, 0);
        tbl[14] = mkv(enc(7'h23, 3'd2, 5'd0), 32'h20C, 32'hCAFE_F00D, 0, 5'd0, 2, 0,
                      0, 32'h20C, 0, 1, 3, 32'h20C, 4'hF, 32'hCAFE_F00D, 1);
        tbl[15] = mkv(32'h0, 32'h999, 32'h5, 0, 5'd0, 0, 0,
                      0, 32'h0, 0, 1, 0, 0, 4'h0, 0, 0);

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req", 32'(dmem_req_o), 32'h0);
        chk("rst_we", 32'(dmem_we_o), 32'h0);
        chk("rst_addr", dmem_addr_o, 32'h0);
        chk("rst_wdata", dmem_wdata_o, 32'h0);
        chk("rst_be", 32'(dmem_be_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_wb_en", 32'(wb_en_o), 32'h0);
        chk("rst_wb_data", wb_data_o, 32'h0);
        chk("rst_wbaddr", 32'(wbaddr_o), 32'h0);
        chk("rst_exc", 32'(exc_o), 32'h0);

        for (int i = 0; i < 16; i++) run_op(tbl[i]);

        // Reset while a load waits for its data; the late rvalid must be dropped.
        @(negedge clk);
        instr_i = enc(7'h03, 3'd2, 5'd9); alu_i = 32'h800; wbaddr_i = 5'd9;
        dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b1;
        #1;
        chk("wait_rst_req", 32'(dmem_req_o), 32'h1);
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        #1;
        chk("wait_stall", 32'(stall_o), 32'h1);
        chk("wait_no_req", 32'(dmem_req_o), 32'h0);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("post_rst_stall", 32'(stall_o), 32'h0);
        chk("post_rst_req", 32'(dmem_req_o), 32'h0);
        chk("post_rst_wb_en", 32'(wb_en_o), 32'h0);
        run_op(tbl[0]);
        run_op(tbl[5]);

        // Reset while a request is pending without grant.
        @(negedge clk);
        instr_i = enc(7'h03, 3'd2, 5'd9); alu_i = 32'h600; wbaddr_i = 5'd9;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        #1;
        chk("pend_req", 32'(dmem_req_o), 32'h1);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("pend_rst_req", 32'(dmem_req_o), 32'h0);
        chk("pend_rst_stall", 32'(stall_o), 32'h0);

        // Random instruction mix against the reference model.
        for (int n = 0; n < 120; n++) begin
            int pick;
            int f3;
            pick = int'($urandom_range(0, 9));
            f3   = int'($urandom_range(0, 7));
            if ((pick <= 1) && ($urandom_range(0, 3) != 0))
                f3 = (pick == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
            rv.rd      = 5'($urandom_range(0, 31));
            rv.alu     = $urandom;
            rv.data    = $urandom;
            rv.rdata   = $urandom;
            rv.pc      = $urandom;
            rv.gnt_dly = int'($urandom_range(0, 3));
            rv.rv_dly  = int'($urandom_range(0, 3));
            case (pick)
                0: rv.instr = {$urandom_range(0, 131071) , 3'(f3), 5'($urandom), 7'h23};
                1: rv.instr = {$urandom_range(0, 131071) , 3'(f3 == 3 ? 4 : f3), 5'($urandom), 7'h03};
                2: rv.instr = {25'($urandom), 7'h33};
                3: rv.instr = {25'($urandom), 7'h13};
                4: rv.instr = {25'($urandom), 7'h37};
                5: rv.instr = {25'($urandom), 7'h17};
                6: rv.instr = {25'($urandom), 7'h6F};
                7: rv.instr = {25'($urandom), 7'h67};
                8: rv.instr = {25'($urandom), 7'h63};
                default: begin
                    rv.instr = 32'h0;
                    rv.rd    = 5'd0;
                end
            endcase
            if (pick == 1 && $urandom_range(0, 7) == 0) rv.instr[14:12] = 3'd3;
            rv = fill_expect(rv);
            run_op(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
